stopwatch_lap: RTL

- Parametrised successor of the 4-digit stopwatch.
- Counts in BCD at TICK_HZ, with a configurable digit count and decimal-point position.
- Adds split/lap hold (display freezes while counting continues), lap-clear from stopped, and a sticky overflow flag.
- Drives the board's multiplexed active-low 7-segment display directly from the single system clock.

---
 rtl/stopwatch_lap.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap.sv
// BCD stopwatch with split/lap hold, lap-clear, sticky overflow and a multiplexed active-low 7-segment driver.
// Optional leading-zero blanking: define STOPWATCH_LEADING_ZERO_BLANK_EN.
module stopwatch_lap #(
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int DP_POS     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  lap,
  output logic [7:0]            Seg,
  output logic                  decimal,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  running,
  output logic                  overflow
);

  localparam int PRESC_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int PW = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = NUM_DIGITS * 4;
  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC_MAX);
  localparam logic [SW-1:0] SCAN_TOP  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] DP_IDX    = IW'(DP_POS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_t;

  state_t                state_r;
  logic [1:0]            ss_sync_r, lap_sync_r;
  logic                  ss_prev_r, lap_prev_r;
  logic                  ss_edge_s, lap_edge_s, tick_s, carry_s, wrap_s;
  logic [PW-1:0]         presc_r;
  logic [CW-1:0]         count_r, lap_r, count_inc_s, disp_s;
  logic                  running_r, overflow_r;
  logic [SW-1:0]         scan_r;
  logic [IW-1:0]         idx_r;
  logic [NUM_DIGITS-1:0] an_r, blank_s;
  logic [6:0]            seg_r, seg_s;
  logic                  dp_r;
  logic [3:0]            digit_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Two-flop synchronisers plus previous-value flops for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_sync_r  <= 2'b00;
      lap_sync_r <= 2'b00;
      ss_prev_r  <= 1'b0;
      lap_prev_r <= 1'b0;
    end else begin
      ss_sync_r  <= {ss_sync_r[0], start_stop};
      lap_sync_r <= {lap_sync_r[0], lap};
      ss_prev_r  <= ss_sync_r[1];
      lap_prev_r <= lap_sync_r[1];
    end
  end

  // Press pulses and count tick; start_stop suppresses a coincident lap press
  always_comb begin
    ss_edge_s  = ss_sync_r[1] & ~ss_prev_r;
    lap_edge_s = lap_sync_r[1] & ~lap_prev_r & ~ss_edge_s;
    tick_s     = 1'b0;
    if (((state_r == ST_RUN) || (state_r == ST_LAP)) && (presc_r == PRESC_TOP)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Cascaded BCD increment; carry out of the top digit is the wrap
  always_comb begin
    carry_s     = tick_s;
    count_inc_s = count_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry_s) begin
        if (count_r[i*4 +: 4] == 4'd9) begin
          count_inc_s[i*4 +: 4] = 4'd0;
        end else begin
          count_inc_s[i*4 +: 4] = count_r[i*4 +: 4] + 4'd1;
          carry_s = 1'b0;
        end
      end else begin
        count_inc_s[i*4 +: 4] = count_r[i*4 +: 4];
      end
    end
    wrap_s = carry_s;
  end

  // Control FSM with prescaler, live count, lap register and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      presc_r    <= '0;
      count_r    <= '0;
      lap_r      <= '0;
      running_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN, ST_LAP: presc_r <= (presc_r == PRESC_TOP) ? '0 : presc_r + PW'(1);
        ST_STOP:        presc_r <= lap_edge_s ? '0 : presc_r;
        default:        presc_r <= '0;
      endcase
      if (tick_s) begin
        count_r <= count_inc_s;
        if (wrap_s) overflow_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (ss_edge_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ss_edge_s) begin
            state_r   <= ST_STOP;
            running_r <= 1'b0;
          end else if (lap_edge_s) begin
            state_r <= ST_LAP;
            lap_r   <= count_r;
          end
        end
        ST_LAP: begin
          if (ss_edge_s) begin
            state_r   <= ST_STOP;
            running_r <= 1'b0;
            lap_r     <= '0;
          end else if (lap_edge_s) begin
            state_r <= ST_RUN;
          end
        end
        ST_STOP: begin
          if (ss_edge_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else if (lap_edge_s) begin
            state_r    <= ST_IDLE;
            count_r    <= '0;
            lap_r      <= '0;
            overflow_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  // Display source selection, leading-zero blanking and segment lookup
  always_comb begin
    if (state_r == ST_LAP) begin
      disp_s = lap_r;
    end else begin
      disp_s = count_r;
    end
    blank_s = '0;
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    begin
      logic lead_s;
      lead_s = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        lead_s     = lead_s & (disp_s[i*4 +: 4] == 4'd0);
        blank_s[i] = lead_s & (i > DP_POS);
      end
    end
`endif
    digit_s = disp_s[{idx_r, 2'b00} +: 4];
    if (blank_s[idx_r]) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = seg_decode(digit_s);
    end
  end

  // Digit scan and registered segment/anode/decimal-point outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_r <= '0;
      idx_r  <= '0;
      an_r   <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      seg_r  <= 7'b1000000;
      dp_r   <= (DP_POS == 0) ? 1'b0 : 1'b1;
    end else begin
      if (scan_r == SCAN_TOP) begin
        scan_r <= '0;
        idx_r  <= (idx_r == IDX_TOP) ? '0 : idx_r + IW'(1);
      end else begin
        scan_r <= scan_r + SW'(1);
      end
      an_r  <= ~(NUM_DIGITS'(1) << idx_r);
      seg_r <= seg_s;
      dp_r  <= (idx_r == DP_IDX) ? 1'b0 : 1'b1;
    end
  end

  assign Seg      = {dp_r, seg_r};
  assign decimal  = dp_r;
  assign an       = an_r;
  assign running  = running_r;
  assign overflow = overflow_r;

endmodule
